mult_sched: RTL and testbench

Round-robin scheduler that shares one Booth multiplier (`multiplier_top`) among `NUM_REQ` requesters. It arbitrates pending requests and latches the winner's operands. It then clears the multiplier, pulses its start sequence, and waits for `mult_ready`. Finally it returns the signed product to the winning requester. It sits between the requesting units and the single multiplier instance.

---
 rtl/mult_sched_pkg.sv | 20 ++
 rtl/mult_sched_arbiter.sv | 30 +++
 rtl/mult_sched.sv | 125 ++++++++++++
 tb/tb_mult_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the multiplier scheduler.
package mult_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN,
    RESP
  } state_t;

  // Cycles the multiplier is held in reset before operands are set up.
  localparam int CLEAR_CYCLES = 1;

  // Width of a requester id for a given requester count.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/mult_sched_arbiter.sv
// Round-robin winner selection: lowest requesting index at or above rr_ptr, wrapping.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any,
  output logic [ID_W-1:0]    winner_id
);

  logic [ID_W-1:0] cand;

  // Scan requesters in rotated order and keep the first one found.
  always_comb begin
    any       = 1'b0;
    winner_id = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + int'(i)) % NUM_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        winner_id = cand;
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Shares one multiplier among NUM_REQ requesters with round-robin arbitration.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] op_a,
  input  logic [NUM_REQ*WIDTH-1:0] op_b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [2*WIDTH-1:0]       result,
  output logic                     err,
  output logic                     busy,
  output logic                     mul_reset,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_num_1,
  output logic [WIDTH-1:0]         mul_num_2,
  input  logic                     mul_ready,
  input  logic [2*WIDTH-1:0]       mul_result
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t             state, state_next;
  logic [ID_W-1:0]    id, rr_ptr, winner_id;
  logic               any;
  logic [CNT_W-1:0]   cnt;
  logic               err_flag;
  logic               timed_out;
  logic [NUM_REQ-1:0] id_onehot;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .any       (any),
    .winner_id (winner_id)
  );

  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));
  assign id_onehot = NUM_REQ'(1) << id;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and Moore outputs; multiplier is held in reset outside LOAD/RUN.
  always_comb begin
    state_next = state;
    gnt        = '0;
    done       = '0;
    err        = 1'b0;
    busy       = (state != IDLE);
    mul_reset  = 1'b1;
    mul_start  = 1'b0;
    case (state)
      IDLE: if (any) state_next = CLEAR;
      CLEAR: begin
        if (cnt == '0) gnt = id_onehot;
        if (cnt == CNT_W'(CLEAR_CYCLES - 1)) state_next = LOAD;
      end
      LOAD: begin
        mul_reset  = 1'b0;
        state_next = RUN;
      end
      RUN: begin
        mul_reset = 1'b0;
        mul_start = 1'b1;
        if (mul_ready || timed_out) state_next = RESP;
      end
      RESP: begin
        done       = id_onehot;
        err        = err_flag;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job registers: winner id, operands, result/error and the shared phase counter.
  // The counter restarts on every state change, so it times both CLEAR and RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id        <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      err_flag  <= 1'b0;
      result    <= '0;
      mul_num_1 <= '0;
      mul_num_2 <= '0;
    end else begin
      if (state_next != state)              cnt <= '0;
      else if (state == CLEAR || state == RUN) cnt <= cnt + CNT_W'(1);
      case (state)
        IDLE: if (any) begin
          id        <= winner_id;
          mul_num_1 <= op_a[winner_id*WIDTH +: WIDTH];
          mul_num_2 <= op_b[winner_id*WIDTH +: WIDTH];
        end
        RUN: begin
          if (mul_ready) begin
            result   <= mul_result;
            err_flag <= 1'b0;
          end else if (timed_out) begin
            result   <= '0;
            err_flag <= 1'b1;
          end
        end
        RESP: rr_ptr <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched with a behavioural multiplier stand-in.
module tb_mult_sched;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] op_a, op_b;
  logic [NR-1:0]   gnt, done;
  logic [2*W-1:0]  result;
  logic            err, busy, mul_reset, mul_start;
  logic [W-1:0]    mul_num_1, mul_num_2;
  logic            mul_ready;
  logic [2*W-1:0]  mul_result;

  mult_sched #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .op_a       (op_a),
    .op_b       (op_b),
    .gnt        (gnt),
    .done       (done),
    .result     (result),
    .err        (err),
    .busy       (busy),
    .mul_reset  (mul_reset),
    .mul_start  (mul_start),
    .mul_num_1  (mul_num_1),
    .mul_num_2  (mul_num_2),
    .mul_ready  (mul_ready),
    .mul_result (mul_result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int ptr_m  = 0;

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return sa * sb;
  endfunction

  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic int oh(input logic [NR-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int k = 0; k < NR; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Multiplier stand-in: ready 'lat' start cycles after release, unless stalled.
  int          lat = 3;
  bit          stall = 1'b0;
  bit          force_ready = 1'b0;
  int          mcnt = 0;
  logic        mrdy = 1'b0;
  logic [15:0] mprod = '0;

  always @(posedge clk) begin
    if (mul_reset) begin
      mcnt <= 0;
      mrdy <= 1'b0;
    end else if (mul_start && !stall) begin
      mcnt <= mcnt + 1;
      if (mcnt + 1 >= lat) begin
        mrdy  <= 1'b1;
        mprod <= smul(mul_num_1, mul_num_2);
      end
    end
  end
  assign mul_ready  = mrdy | force_ready;
  assign mul_result = mprod;

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic rand_ops;
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic wait_gnt(output int id, output int n);
    id = -1;
    n  = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (gnt !== '0) begin
        id = oh(gnt);
        n  = k;
        return;
      end
    end
  endtask

  task automatic wait_done(output int id, output logic [15:0] r, output logic e, output int n);
    id = -1;
    n  = -1;
    r  = 'x;
    e  = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done !== '0) begin
        id = oh(done);
        r  = result;
        e  = err;
        n  = k;
        return;
      end
    end
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;
  endtask

  task automatic test_reset;
    reset = 1'b0; req = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== '0)   $display("FAIL reset_gnt: got %b want 0", gnt); else passes++;
    checks++; if (done !== '0)  $display("FAIL reset_done: got %b want 0", done); else passes++;
    checks++; if (result !== '0) $display("FAIL reset_result: got %h want 0", result); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (mul_start !== 1'b0) $display("FAIL reset_mul_start: got %b want 0", mul_start); else passes++;
    checks++; if (mul_reset !== 1'b1) $display("FAIL reset_mul_reset: got %b want 1", mul_reset); else passes++;
    checks++; if ({mul_num_1, mul_num_2} !== '0) $display("FAIL reset_operands: got %h want 0", {mul_num_1, mul_num_2}); else passes++;
    reset = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || mul_reset !== 1'b1) $display("FAIL idle_after_reset: busy %b mul_reset %b want 0/1", busy, mul_reset); else passes++;
  endtask

  task automatic test_single;
    int id, n, exp_id;
    logic [15:0] r, exp;
    logic e;
    lat = 3;
    set_ops(1, 8'd53, 8'd46);
    req    = 4'b0010;
    exp_id = pick(req, ptr_m);
    exp    = smul(8'd53, 8'd46);
    @(negedge clk);
    checks++; if (gnt !== NR'(1) << exp_id) $display("FAIL single_gnt_n1: got %b want id %0d", gnt, exp_id); else passes++;
    checks++; if (mul_num_1 !== 8'd53 || mul_num_2 !== 8'd46) $display("FAIL single_operands: got %0d,%0d want 53,46", mul_num_1, mul_num_2); else passes++;
    checks++; if (mul_reset !== 1'b1 || mul_start !== 1'b0 || busy !== 1'b1) $display("FAIL single_clear: rst %b start %b busy %b want 1/0/1", mul_reset, mul_start, busy); else passes++;
    req = '0;
    rand_ops;
    @(negedge clk);
    checks++; if (mul_reset !== 1'b0 || mul_start !== 1'b0 || gnt !== '0) $display("FAIL single_load: rst %b start %b gnt %b want 0/0/0", mul_reset, mul_start, gnt); else passes++;
    @(negedge clk);
    checks++; if (mul_start !== 1'b1) $display("FAIL single_start_n3: got %b want 1", mul_start); else passes++;
    wait_done(id, r, e, n);
    checks++; if (n !== lat + 1) $display("FAIL single_latency: got %0d want %0d", n, lat + 1); else passes++;
    checks++; if (id !== exp_id) $display("FAIL single_done_id: got %0d want %0d", id, exp_id); else passes++;
    checks++; if (r !== 16'd2438 || r !== exp) $display("FAIL single_result: got %0d want 2438", r); else passes++;
    checks++; if (e !== 1'b0) $display("FAIL single_err: got %b want 0", e); else passes++;
    @(negedge clk);
    checks++; if (done !== '0 || busy !== 1'b0 || result !== exp) $display("FAIL single_after: done %b busy %b result %0d want 0/0/%0d", done, busy, result, exp); else passes++;
    ptr_m = (exp_id + 1) % NR;
  endtask

  task automatic test_signed;
    logic [7:0]  av [2];
    logic [7:0]  bv [2];
    logic [15:0] want [2];
    int id, n, exp_id;
    logic [15:0] r;
    logic e;
    av[0] = -8'sd8;  bv[0] = -8'sd2;  want[0] = 16'sd16;
    av[1] = 8'sd99;  bv[1] = -8'sd97; want[1] = -16'sd9603;
    for (int k = 0; k < 2; k++) begin
      lat = $urandom_range(1, 8);
      set_ops(0, av[k], bv[k]);
      req    = 4'b0001;
      exp_id = pick(req, ptr_m);
      wait_gnt(id, n);
      checks++; if (id !== exp_id) $display("FAIL signed_gnt%0d: got %0d want %0d", k, id, exp_id); else passes++;
      req = '0;
      rand_ops;
      wait_done(id, r, e, n);
      checks++; if (r !== want[k] || e !== 1'b0) $display("FAIL signed_result%0d: got %0d err %b want %0d err 0", k, $signed(r), e, $signed(want[k])); else passes++;
      ptr_m = (exp_id + 1) % NR;
    end
  endtask

  task automatic test_contention;
    int id, n, exp_id;
    logic [15:0] r, exp;
    logic e;
    apply_reset;
    rand_ops;
    lat = $urandom_range(1, 6);
    req = 4'b0101;
    // job 1: both pending, pointer at 0
    exp_id = pick(req, ptr_m);
    wait_gnt(id, n);
    checks++; if (id !== exp_id || n !== 1) $display("FAIL cont_gnt_first: got %0d after %0d want %0d after 1", id, n, exp_id); else passes++;
    exp = smul(op_a[exp_id*W +: W], op_b[exp_id*W +: W]);
    req[exp_id] = 1'b0;
    rand_ops;
    wait_done(id, r, e, n);
    checks++; if (id !== exp_id || r !== exp) $display("FAIL cont_done_first: got id %0d res %0d want id %0d res %0d", id, r, exp_id, exp); else passes++;
    ptr_m = (exp_id + 1) % NR;
    // job 2: remaining request is granted back to back
    exp_id = pick(req, ptr_m);
    wait_gnt(id, n);
    checks++; if (id !== exp_id || n !== 2) $display("FAIL cont_gnt_second: got %0d after %0d want %0d after 2", id, n, exp_id); else passes++;
    exp = smul(op_a[exp_id*W +: W], op_b[exp_id*W +: W]);
    req[exp_id] = 1'b0;
    rand_ops;
    @(negedge clk);
    req[0] = 1'b1;
    wait_done(id, r, e, n);
    checks++; if (id !== exp_id || r !== exp) $display("FAIL cont_done_second: got id %0d res %0d want id %0d res %0d", id, r, exp_id, exp); else passes++;
    ptr_m = (exp_id + 1) % NR;
    // job 3: requester re-raised during job 2
    exp_id = pick(req, ptr_m);
    wait_gnt(id, n);
    checks++; if (id !== exp_id || n !== 2) $display("FAIL cont_gnt_third: got %0d after %0d want %0d after 2", id, n, exp_id); else passes++;
    exp = smul(op_a[exp_id*W +: W], op_b[exp_id*W +: W]);
    req = '0;
    wait_done(id, r, e, n);
    checks++; if (id !== exp_id || r !== exp) $display("FAIL cont_done_third: got id %0d res %0d want id %0d res %0d", id, r, exp_id, exp); else passes++;
    ptr_m = (exp_id + 1) % NR;
  endtask

  task automatic test_fairness;
    int id, n, exp_id;
    logic [15:0] r, exp;
    logic e;
    apply_reset;
    rand_ops;
    req = '1;
    for (int j = 0; j < 8; j++) begin
      exp_id = pick(req, ptr_m);
      wait_gnt(id, n);
      checks++; if (id !== exp_id || (j > 0 && n !== 2)) $display("FAIL fair_gnt%0d: got %0d after %0d want %0d", j, id, n, exp_id); else passes++;
      exp = smul(op_a[exp_id*W +: W], op_b[exp_id*W +: W]);
      lat = $urandom_range(1, 10);
      rand_ops;
      wait_done(id, r, e, n);
      checks++; if (id !== exp_id || r !== exp || e !== 1'b0) $display("FAIL fair_done%0d: got id %0d res %0d err %b want id %0d res %0d", j, id, r, e, exp_id, exp); else passes++;
      ptr_m = (exp_id + 1) % NR;
    end
    req = '0;
  endtask

  task automatic test_timeout;
    int id, n, exp_id;
    logic [15:0] r;
    logic e;
    stall = 1'b1;
    rand_ops;
    req    = 4'b1000;
    exp_id = pick(req, ptr_m);
    wait_gnt(id, n);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mul_start !== 1'b1) $display("FAIL to_start: got %b want 1", mul_start); else passes++;
    wait_done(id, r, e, n);
    checks++; if (n !== TO) $display("FAIL to_cycles: got %0d want %0d", n, TO); else passes++;
    checks++; if (id !== exp_id || e !== 1'b1 || r !== '0) $display("FAIL to_done: id %0d err %b res %0d want id %0d err 1 res 0", id, e, r, exp_id); else passes++;
    checks++; if (mul_reset !== 1'b1 || mul_start !== 1'b0) $display("FAIL to_mul_held: rst %b start %b want 1/0", mul_reset, mul_start); else passes++;
    @(negedge clk);
    checks++; if (err !== 1'b0 || done !== '0) $display("FAIL to_pulse: err %b done %b want 0/0", err, done); else passes++;
    stall = 1'b0;
    ptr_m = (exp_id + 1) % NR;
  endtask

  task automatic test_ready_vs_timeout;
    int id, n, exp_id;
    logic [15:0] r, exp;
    logic e;
    lat = TO - 1;
    rand_ops;
    req    = 4'b0100;
    exp_id = pick(req, ptr_m);
    wait_gnt(id, n);
    exp = smul(op_a[exp_id*W +: W], op_b[exp_id*W +: W]);
    req = '0;
    wait_done(id, r, e, n);
    checks++; if (n !== TO + 2) $display("FAIL tie_cycles: got %0d want %0d", n, TO + 2); else passes++;
    checks++; if (e !== 1'b0 || r !== exp || id !== exp_id) $display("FAIL tie_ready_wins: err %b res %0d id %0d want err 0 res %0d id %0d", e, r, id, exp, exp_id); else passes++;
    ptr_m = (exp_id + 1) % NR;
  endtask

  task automatic test_idle_ready;
    logic [15:0] held;
    @(negedge clk);
    held = result;
    force_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== '0 || result !== held) $display("FAIL idle_ready%0d: busy %b done %b res %0d want 0/0/%0d", k, busy, done, result, held); else passes++;
    end
    force_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int id, n, exp_id, seen;
    logic [15:0] r, exp;
    logic e;
    stall = 1'b1;
    rand_ops;
    req = 4'b0010;
    wait_gnt(id, n);
    @(negedge clk);
    @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (mul_start !== 1'b1) $display("FAIL rmr_in_run: got %b want 1", mul_start); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (mul_start !== 1'b0 || mul_reset !== 1'b1 || busy !== 1'b0) $display("FAIL rmr_async: start %b rst %b busy %b want 0/1/0", mul_start, mul_reset, busy); else passes++;
    checks++; if (done !== '0 || gnt !== '0 || err !== 1'b0 || result !== '0) $display("FAIL rmr_outputs: done %b gnt %b err %b res %0d want 0", done, gnt, err, result); else passes++;
    req = '0;
    seen = 0;
    @(negedge clk);
    if (done !== '0) seen++;
    reset = 1'b1;
    ptr_m = 0;
    stall = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done !== '0) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL rmr_no_done: got %0d pulses want 0", seen); else passes++;
    lat = 4;
    rand_ops;
    req    = 4'b0100;
    exp_id = pick(req, ptr_m);
    wait_gnt(id, n);
    checks++; if (id !== exp_id) $display("FAIL rmr_regrant: got %0d want %0d", id, exp_id); else passes++;
    exp = smul(op_a[exp_id*W +: W], op_b[exp_id*W +: W]);
    req = '0;
    wait_done(id, r, e, n);
    checks++; if (id !== exp_id || r !== exp || e !== 1'b0) $display("FAIL rmr_new_job: id %0d res %0d err %b want id %0d res %0d", id, r, e, exp_id, exp); else passes++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_signed;
    test_contention;
    test_fairness;
    test_timeout;
    test_ready_vs_timeout;
    test_idle_ready;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
